// File: rtl/scan_pkg.sv
// Shared widths, sizes and helpers for the scan sequencer and its prescaler.
package scan_pkg;

  localparam int SEL_W     = 3;
  localparam int NUM_OUT   = 8;
  localparam int CLK_DIV_W = 16;

  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_LOAD,
    ACT_TICK
  } act_t;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] val,
                                                 input logic [SEL_W-1:0] last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Step prescaler: counts 0..CLK_DIV-1 while running and flags the terminal count.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [CLK_DIV_W-1:0] TERM = CLK_DIV_W'(CLK_DIV - 1);

  logic [CLK_DIV_W-1:0] count_reg;
  logic [CLK_DIV_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (run) begin
      count_next = (count_reg == TERM) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // With CLK_DIV=1 TERM is 0, so every running cycle ticks.
  assign tick = run && (count_reg == TERM);

endmodule

// File: rtl/scan_sequencer.sv
// Scan select generator for a 3-to-8 decoder: prescaled up/down stepping,
// clamped load, and a one-cycle wrap pulse.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LAST    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hold,
  input  logic             dir,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'((LAST < NUM_OUT) ? LAST : NUM_OUT - 1);

  logic             tick;
  logic             presc_clr;
  logic             presc_run;
  act_t             act;
  logic [SEL_W-1:0] sel_reg;
  logic [SEL_W-1:0] sel_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             valid_reg;
  logic             valid_next;

  // A load restarts the step period, so the prescaler is cleared rather than run.
  assign presc_clr = load || !en;
  assign presc_run = en && !hold && !load;

  scan_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .run  (presc_run),
    .tick (tick)
  );

  always_comb begin
    act        = ACT_IDLE;
    sel_next   = sel_reg;
    wrap_next  = 1'b0;
    valid_next = en;

    if (load) begin
      act = ACT_LOAD;
    end else if (tick) begin
      act = ACT_TICK;
    end

    case (act)
      ACT_LOAD: begin
        sel_next = clamp_sel(load_val, LAST_SEL);
      end
      ACT_TICK: begin
        if (sel_reg > LAST_SEL) begin
          sel_next  = '0;
          wrap_next = 1'b1;
        end else if (!dir) begin
          if (sel_reg == LAST_SEL) begin
            sel_next  = '0;
            wrap_next = 1'b1;
          end else begin
            sel_next = sel_reg + 1'b1;
          end
        end else begin
          if (sel_reg == '0) begin
            sel_next  = LAST_SEL;
            wrap_next = 1'b1;
          end else begin
            sel_next = sel_reg - 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_reg   <= '0;
      wrap_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      sel_reg   <= sel_next;
      wrap_reg  <= wrap_next;
      valid_reg <= valid_next;
    end
  end

  assign sel       = sel_reg;
  assign wrap      = wrap_reg;
  assign sel_valid = valid_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer across three parameter sets
// (4/7 nominal, 1/5 fast clamp, 2/0 single-output).
module tb_scan_sequencer;

  typedef struct {
    int         dut;
    logic [2:0] sel;
    logic       wrap;
    logic       valid;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_v      [3];
  logic       en_v       [3];
  logic       hold_v     [3];
  logic       dir_v      [3];
  logic       load_v     [3];
  logic [2:0] load_val_v [3];
  logic [2:0] sel_v      [3];
  logic       valid_v    [3];
  logic       wrap_v     [3];

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  scan_sequencer #(.CLK_DIV(4), .LAST(7)) dut_a (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .hold(hold_v[0]), .dir(dir_v[0]),
    .load(load_v[0]), .load_val(load_val_v[0]),
    .sel(sel_v[0]), .sel_valid(valid_v[0]), .wrap(wrap_v[0])
  );

  scan_sequencer #(.CLK_DIV(1), .LAST(5)) dut_b (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .hold(hold_v[1]), .dir(dir_v[1]),
    .load(load_v[1]), .load_val(load_val_v[1]),
    .sel(sel_v[1]), .sel_valid(valid_v[1]), .wrap(wrap_v[1])
  );

  scan_sequencer #(.CLK_DIV(2), .LAST(0)) dut_c (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .hold(hold_v[2]), .dir(dir_v[2]),
    .load(load_v[2]), .load_val(load_val_v[2]),
    .sel(sel_v[2]), .sel_valid(valid_v[2]), .wrap(wrap_v[2])
  );

  // Monitor: everything queued at the last rising edge is checked on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (sel_v[mon_e.dut] !== mon_e.sel || wrap_v[mon_e.dut] !== mon_e.wrap ||
          valid_v[mon_e.dut] !== mon_e.valid) begin
        errors++;
        $display("FAIL %s dut%0d: got sel=%0d wrap=%b valid=%b, expected sel=%0d wrap=%b valid=%b",
                 mon_e.name, mon_e.dut, sel_v[mon_e.dut], wrap_v[mon_e.dut], valid_v[mon_e.dut],
                 mon_e.sel, mon_e.wrap, mon_e.valid);
      end else begin
        $display("ok   %s dut%0d: sel=%0d wrap=%b valid=%b",
                 mon_e.name, mon_e.dut, sel_v[mon_e.dut], wrap_v[mon_e.dut], valid_v[mon_e.dut]);
      end
    end
  end

  // One clock edge with the current inputs; queue the outputs expected after it.
  task automatic step(input int d, input int s, input bit w, input bit v, input string nm);
    exp_t e;
    @(posedge clk);
    e.dut   = d;
    e.sel   = 3'(s);
    e.wrap  = w;
    e.valid = v;
    e.name  = nm;
    q.push_back(e);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d]      = 1'b1;
      en_v[d]       = 1'b0;
      hold_v[d]     = 1'b0;
      dir_v[d]      = 1'b0;
      load_v[d]     = 1'b0;
      load_val_v[d] = 3'd0;
    end

    // ---------------- dut_a: CLK_DIV=4, LAST=7 ----------------
    step(0, 0, 0, 0, "a_reset");
    step(0, 0, 0, 0, "a_reset");
    rst_v[0] = 1'b0; en_v[0] = 1'b1;
    for (int k = 1; k <= 34; k++)
      step(0, (k / 4) % 8, (k % 4 == 0) && ((k / 4) % 8 == 0), 1, "a_up_scan");
    dir_v[0] = 1'b1;
    for (int k = 35; k <= 44; k++) begin
      int t;
      t = (k >= 36) ? (k - 32) / 4 : 0;
      step(0, (8 - t) % 8, k == 36, 1, "a_down_scan");
    end
    dir_v[0] = 1'b0;
    for (int k = 45; k <= 47; k++) step(0, 5, 0, 1, "a_pre_load");
    load_v[0] = 1'b1; load_val_v[0] = 3'd5;
    step(0, 5, 0, 1, "a_load_on_tick");
    load_v[0] = 1'b0;
    for (int k = 49; k <= 51; k++) step(0, 5, 0, 1, "a_after_load");
    step(0, 6, 0, 1, "a_tick_after_load");
    step(0, 6, 0, 1, "a_pre_hold");
    step(0, 6, 0, 1, "a_pre_hold");
    hold_v[0] = 1'b1;
    for (int k = 55; k <= 64; k++) step(0, 6, 0, 1, "a_hold");
    hold_v[0] = 1'b0;
    step(0, 6, 0, 1, "a_hold_release");
    step(0, 7, 0, 1, "a_tick_after_hold");
    for (int k = 67; k <= 69; k++) step(0, 7, 0, 1, "a_count");
    step(0, 0, 1, 1, "a_wrap_up");
    step(0, 0, 0, 1, "a_pre_disable");
    step(0, 0, 0, 1, "a_pre_disable");
    en_v[0] = 1'b0;
    step(0, 0, 0, 0, "a_disabled");
    step(0, 0, 0, 0, "a_disabled");
    en_v[0] = 1'b1;
    for (int k = 75; k <= 77; k++) step(0, 0, 0, 1, "a_reenable");
    step(0, 1, 0, 1, "a_first_tick_reenable");
    load_v[0] = 1'b1; load_val_v[0] = 3'd6;
    step(0, 6, 0, 1, "a_load6");
    load_v[0] = 1'b0;
    step(0, 6, 0, 1, "a_mid_count");
    step(0, 6, 0, 1, "a_mid_count");
    rst_v[0] = 1'b1; load_v[0] = 1'b1; load_val_v[0] = 3'd3;
    step(0, 0, 0, 0, "a_reset_over_load");
    rst_v[0] = 1'b0; load_v[0] = 1'b0;
    for (int k = 83; k <= 85; k++) step(0, 0, 0, 1, "a_after_reset");
    step(0, 1, 0, 1, "a_first_tick_after_reset");

    // ---------------- dut_b: CLK_DIV=1, LAST=5 ----------------
    step(1, 0, 0, 0, "b_reset");
    step(1, 0, 0, 0, "b_reset");
    rst_v[1] = 1'b0; en_v[1] = 1'b1; load_v[1] = 1'b1; load_val_v[1] = 3'd7;
    step(1, 5, 0, 1, "b_load_clamp");
    load_v[1] = 1'b0;
    for (int j = 1; j <= 8; j++)
      step(1, (j - 1) % 6, (j - 1) % 6 == 0, 1, "b_up_every_cycle");
    dir_v[1] = 1'b1;
    step(1, 0, 0, 1, "b_down");
    step(1, 5, 1, 1, "b_down_wrap_to_last");
    step(1, 4, 0, 1, "b_down");
    hold_v[1] = 1'b1;
    step(1, 4, 0, 1, "b_hold");
    hold_v[1] = 1'b0;
    step(1, 3, 0, 1, "b_hold_release");

    // ---------------- dut_c: CLK_DIV=2, LAST=0 ----------------
    step(2, 0, 0, 0, "c_reset");
    rst_v[2] = 1'b0; en_v[2] = 1'b1;
    step(2, 0, 0, 1, "c_no_tick");
    step(2, 0, 1, 1, "c_wrap_each_tick");
    step(2, 0, 0, 1, "c_no_tick");
    step(2, 0, 1, 1, "c_wrap_each_tick");
    load_v[2] = 1'b1; load_val_v[2] = 3'd3;
    step(2, 0, 0, 1, "c_load_clamp_zero");
    load_v[2] = 1'b0; dir_v[2] = 1'b1;
    step(2, 0, 0, 1, "c_no_tick_down");
    step(2, 0, 1, 1, "c_wrap_down");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
